// File: rtl/key_event_arbiter.sv
// Round-robin scheduler for debounced key pulses. Each press is held as a pending
// request and issued one at a time over a valid/ack handshake, with an idle gap between issues.
module key_event_arbiter #(
  parameter int N          = 5,
  parameter int GAP_CYCLES = 4,
  parameter int CW         = 8
) (
  input  logic         CLK,
  input  logic         RSTn,
  input  logic [N-1:0] Key_Input,
  input  logic         Evt_Ack,
  output logic         Evt_Valid,
  output logic [N-1:0] Evt_Onehot,
  output logic [N-1:0] Pending,
  output logic         Overrun,
  input  logic         Clr_Overrun
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  state_t         state, state_nx;
  logic [CW-1:0]  gap_cnt, gap_cnt_nx;
  logic [PW-1:0]  ptr, ptr_nx;
  logic           valid_nx;
  logic [N-1:0]   onehot_nx;
  logic [N-1:0]   clr;
  logic [N-1:0]   ovr_hit;
  logic           grant_found;
  logic [PW-1:0]  grant_idx;

  // Search starts one past the last grant and wraps, so the last winner has lowest priority.
  always_comb begin
    int unsigned   idx;
    logic [PW-1:0] cand;
    grant_found = 1'b0;
    grant_idx   = ptr;
    idx         = 0;
    cand        = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx  = (32'(ptr) + k) % N;
      cand = PW'(idx);
      if (!grant_found && Pending[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    gap_cnt_nx = gap_cnt;
    ptr_nx     = ptr;
    valid_nx   = Evt_Valid;
    onehot_nx  = Evt_Onehot;
    clr        = '0;
    case (state)
      IDLE: begin
        if (grant_found) begin
          clr[grant_idx]       = 1'b1;
          ptr_nx               = grant_idx;
          valid_nx             = 1'b1;
          onehot_nx            = '0;
          onehot_nx[grant_idx] = 1'b1;
          state_nx             = ISSUE;
        end
      end
      ISSUE: begin
        if (Evt_Ack) begin
          valid_nx  = 1'b0;
          onehot_nx = '0;
          if (GAP_CYCLES == 0) begin
            state_nx = IDLE;
          end else begin
            state_nx   = GAP;
            gap_cnt_nx = CW'(GAP_CYCLES);
          end
        end
      end
      GAP: begin
        if (gap_cnt <= CW'(1)) begin
          state_nx   = IDLE;
          gap_cnt_nx = '0;
        end else begin
          gap_cnt_nx = gap_cnt - CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // A press on the bit being granted this cycle re-arms it rather than counting as overrun.
  assign ovr_hit = Key_Input & Pending & ~clr;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state      <= IDLE;
      gap_cnt    <= '0;
      ptr        <= PW'(N - 1);
      Evt_Valid  <= 1'b0;
      Evt_Onehot <= '0;
      Pending    <= '0;
      Overrun    <= 1'b0;
    end else begin
      state      <= state_nx;
      gap_cnt    <= gap_cnt_nx;
      ptr        <= ptr_nx;
      Evt_Valid  <= valid_nx;
      Evt_Onehot <= onehot_nx;
      Pending    <= (Pending & ~clr) | Key_Input;
      if (|ovr_hit)
        Overrun <= 1'b1;
      else if (Clr_Overrun)
        Overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_key_event_arbiter.sv
// Scoreboard bench for key_event_arbiter: a timestamp-based reference model queues expected
// grants; a monitor pops them as events appear and checks Pending/Overrun/Valid every cycle.
module tb_key_event_arbiter;

  localparam int N  = 5;
  localparam int G  = 4;
  localparam int CW = 8;

  logic         CLK;
  logic         RSTn;
  logic [N-1:0] Key_Input;
  logic         Evt_Ack;
  logic         Evt_Valid;
  logic [N-1:0] Evt_Onehot;
  logic [N-1:0] Pending;
  logic         Overrun;
  logic         Clr_Overrun;

  key_event_arbiter #(.N(N), .GAP_CYCLES(G), .CW(CW)) dut (
    .CLK(CLK), .RSTn(RSTn), .Key_Input(Key_Input), .Evt_Ack(Evt_Ack),
    .Evt_Valid(Evt_Valid), .Evt_Onehot(Evt_Onehot), .Pending(Pending),
    .Overrun(Overrun), .Clr_Overrun(Clr_Overrun)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending set, last-grant pointer, and the earliest edge a grant may occur.
  logic [N-1:0] m_pend;
  int           m_ptr;
  bit           m_busy;
  int           m_ready;
  bit           m_ovr;
  int           cyc;
  logic [N-1:0] q[$];

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      m_pend = '0; m_ptr = N - 1; m_busy = 0; m_ready = 0; m_ovr = 0; cyc = 0;
      q.delete();
    end else begin
      int g;
      bit ovr_set;
      logic [N-1:0] oh;
      g = -1; ovr_set = 0;
      cyc++;
      if (m_busy) begin
        if (Evt_Ack) begin
          m_busy  = 0;
          m_ready = cyc + G + 1;
        end
      end else if (cyc >= m_ready && m_pend != '0) begin
        for (int k = 1; k <= N; k++)
          if (g < 0 && m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        m_ptr = g; m_busy = 1;
        oh = '0; oh[g] = 1'b1;
        q.push_back(oh);
      end
      for (int i = 0; i < N; i++)
        if (Key_Input[i] && m_pend[i] && i != g) ovr_set = 1;
      if (ovr_set) m_ovr = 1;
      else if (Clr_Overrun) m_ovr = 0;
      if (g >= 0) m_pend[g] = 1'b0;
      m_pend = m_pend | Key_Input;
    end
  end

  // Monitor
  bit           prev_valid = 0;
  logic [N-1:0] cur_exp = '0;

  always @(posedge CLK) begin
    #1;
    if (!RSTn) begin
      prev_valid = 0;
    end else begin
      chk("pending", 32'(Pending), 32'(m_pend));
      chk("overrun", 32'(Overrun), 32'(m_ovr));
      chk("evt_valid", 32'(Evt_Valid), 32'(m_busy));
      if (Evt_Valid && !prev_valid) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_event: got %0b expected none at %0t", Evt_Onehot, $time);
        end else begin
          cur_exp = q.pop_front();
          chk("evt_onehot", 32'(Evt_Onehot), 32'(cur_exp));
        end
      end else if (Evt_Valid) begin
        chk("onehot_stable", 32'(Evt_Onehot), 32'(cur_exp));
      end else begin
        chk("onehot_idle_zero", 32'(Evt_Onehot), 32'(0));
      end
      prev_valid = Evt_Valid;
    end
  end

  task automatic step(input logic [N-1:0] k, input logic a, input logic c);
    Key_Input = k; Evt_Ack = a; Clr_Overrun = c;
    @(negedge CLK);
  endtask

  task automatic idle(input int n, input logic a);
    for (int i = 0; i < n; i++) step('0, a, 1'b0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"},   32'(Evt_Valid),  32'(0));
    chk({tag, "_onehot"},  32'(Evt_Onehot), 32'(0));
    chk({tag, "_pending"}, 32'(Pending),    32'(0));
    chk({tag, "_overrun"}, 32'(Overrun),    32'(0));
  endtask

  initial begin
    RSTn = 1'b0; Key_Input = '0; Evt_Ack = 1'b0; Clr_Overrun = 1'b0;
    @(negedge CLK); @(negedge CLK);
    chk_zero_outputs("reset");
    RSTn = 1'b1;
    @(negedge CLK);

    // Single press on key 2, ack tied high
    step(5'b00100, 1'b1, 1'b0);
    idle(12, 1'b1);

    // Simultaneous presses on keys 0, 3, 4
    step(5'b11001, 1'b1, 1'b0);
    idle(20, 1'b1);

    // Keys 1 and 4 pulsing continuously
    for (int i = 0; i < 30; i++) step(5'b10010, 1'b1, 1'b0);
    idle(15, 1'b1);
    step('0, 1'b0, 1'b1);

    // Ack withheld with key 0 presented; second press pends, third overruns
    step(5'b00001, 1'b0, 1'b0);
    idle(3, 1'b0);
    step(5'b00001, 1'b0, 1'b0);
    idle(2, 1'b0);
    step(5'b00001, 1'b0, 1'b0);
    idle(3, 1'b0);
    step('0, 1'b0, 1'b1);
    idle(1, 1'b0);
    step(5'b00001, 1'b0, 1'b1);
    idle(1, 1'b0);
    idle(20, 1'b1);

    // Reset while in ISSUE with Pending = 10110
    step(5'b00001, 1'b0, 1'b0);
    idle(1, 1'b0);
    step(5'b10110, 1'b0, 1'b0);
    idle(1, 1'b0);
    RSTn = 1'b0;
    #1;
    chk_zero_outputs("async_reset");
    @(negedge CLK); @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    step(5'b10001, 1'b1, 1'b0);
    idle(15, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] k;
      k = '0;
      for (int b = 0; b < N; b++) k[b] = ($urandom_range(0, 99) < 12);
      step(k, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) == 0));
    end
    idle(60, 1'b1);
    chk("queue_drained", 32'(q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_event_arbiter.md
# key_event_arbiter

Front-end scheduler for the key/toggle path: captures single-cycle debounced key pulses from N keys, holds each as a pending request, and issues them one at a time, round-robin, to the downstream toggle register over a valid/ack handshake. It sits between the key debouncers and the pin-state toggle block. It replaces fixed priority, so simultaneous presses are serialised instead of lost. Back-to-back issues are separated by a programmable hold-off gap.

## Interface
Parameters:
- N, 5, number of keys / request lines
- GAP_CYCLES, 4, idle cycles enforced after each acknowledged event; 0 allowed
- CW, 8, width of the gap counter; must satisfy GAP_CYCLES < 2^CW

Ports:
- CLK  in  1  clock; all logic on rising edge
- RSTn  in  1  reset, asynchronous, active-low
- Key_Input  in  N  debounced key pulses, one cycle wide per press, active-high
- Evt_Ack  in  1  downstream accepts the presented event
- Evt_Valid  out  1  event presented on Evt_Onehot
- Evt_Onehot  out  N  one-hot key index of the current event; all zero when Evt_Valid=0
- Pending  out  N  registered pending-request vector
- Overrun  out  1  sticky: a press arrived on a key whose request was already pending
- Clr_Overrun  in  1  synchronous clear of Overrun

## Operation
- Reset values: Evt_Valid=0, Evt_Onehot=0, Pending=0, Overrun=0, state=IDLE, gap counter=0, round-robin pointer=N-1 so key 0 has first priority.
- Capture: each edge, Pending[i] <= (Pending[i] & ~clr[i]) | Key_Input[i]. clr[i] is 1 only for the bit being granted that cycle.
- Set and clear on the same bit in the same cycle: set wins. Pending stays 1 and no overrun is raised.
- Overrun sets when Key_Input[i]=1, Pending[i]=1 and bit i is not being granted that cycle. The press is absorbed.
- Overrun set and Clr_Overrun in the same cycle: set wins.
- Arbitration: round-robin search starting at pointer+1, wrapping modulo N. The first pending index is granted and becomes the new pointer.
- FSM states:
  - IDLE: if Pending != 0, grant one index, load Evt_Onehot, set Evt_Valid=1, clear that Pending bit, and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: hold Evt_Valid and Evt_Onehot stable until Evt_Ack=1 is sampled. On Ack, drop Evt_Valid, zero Evt_Onehot, and go to GAP with counter=GAP_CYCLES. If GAP_CYCLES=0, go directly to IDLE instead.
  - GAP: decrement the counter each cycle; move to IDLE on the edge where the counter reads 1. No grant is made in GAP.
- Evt_Ack while Evt_Valid=0 is ignored.
- Reset mid-operation: the in-flight event and all pending requests are discarded and outputs return to reset values immediately (asynchronous).

## Timing
- Key pulse sampled at edge t: Pending visible after t. If the FSM is in IDLE, the grant is registered at edge t+1, so Evt_Valid is high from t+1 (2-edge latency).
- Ack sampled at edge a: Evt_Valid is low after a. The next Evt_Valid rises no earlier than edge a+GAP_CYCLES+1.
- With GAP_CYCLES=0 and Ack tied high: one event every 2 cycles.
- Pending and Overrun are registered outputs, updated each edge.
- No combinational path from any input to any output.

## Test plan
- Reset then single press on key 2, Ack tied 1, GAP=4:
  - Evt_Valid high 1 cycle after Pending[2] sets, with Evt_Onehot=5'b00100.
  - Next grant is blocked for 4 cycles.
- Keys 0, 3 and 4 pulsed in the same cycle after reset, Ack tied 1: events issued in order 00001, 01000, 10000, each separated by GAP+1 cycles. Overrun stays 0.
- Fairness: hold key 1 and key 4 pulsing continuously: grants alternate 00010, 10000, 00010, and so on. Neither key starves; Overrun goes to 1.
- Ack withheld 10 cycles with key 0 presented:
  - Evt_Valid and Evt_Onehot stay stable for all 10 cycles.
  - A second key-0 pulse during the wait sets Pending[0] and raises no overrun.
  - A third key-0 pulse sets Overrun=1.
- Clr_Overrun pulsed alone clears Overrun. Clr_Overrun asserted together with a new overrun event leaves Overrun=1.
- Assert RSTn low while in ISSUE with Pending=5'b10110: all outputs are 0 immediately. After release, the first new press on key 4 is granted before a simultaneous press on key 0 only if the pointer rule says so; with the pointer reset to N-1, key 0 is granted first.
